// File: rtl/ramif_pkg.sv
// Shared constants and types for the nibble-serial RAM interface arbiter.
package ramif_pkg;
   localparam int RAMIF_WIDTH = 4;
   localparam int ADDR_BITS   = 16;
   localparam int SLOT_LEN    = ADDR_BITS / RAMIF_WIDTH;
   localparam int SLOT_BITS   = $clog2(SLOT_LEN);

   localparam logic PORT_RENDER = 1'b0;
   localparam logic PORT_AUX    = 1'b1;

   // One entry of the owner pipeline: which port a slot belongs to, if any.
   typedef struct packed {
      logic valid;
      logic port;
   } owner_t;

   localparam owner_t OWNER_NONE = '{valid: 1'b0, port: 1'b0};
endpackage

// File: rtl/ramif_arbiter_if.sv
// Requester and RAM-pin signals of the arbiter, bundled with directional modports.
interface ramif_arbiter_if;
   import ramif_pkg::*;

   logic [1:0]             req;
   logic [ADDR_BITS-1:0]   addr0;
   logic [ADDR_BITS-1:0]   addr1;
   logic [1:0]             gnt;
   logic [1:0]             rvalid;
   logic [ADDR_BITS-1:0]   rdata;
   logic [RAMIF_WIDTH-1:0] addr_bits;
   logic [RAMIF_WIDTH-1:0] data_bits;

   modport master (
      output req, addr0, addr1, data_bits,
      input  gnt, rvalid, rdata, addr_bits
   );

   modport slave (
      input  req, addr0, addr1, data_bits,
      output gnt, rvalid, rdata, addr_bits
   );
endinterface

// File: rtl/ramif_serdes.sv
// Address shift-out and data shift-in registers, slotted by slot_cnt.
module ramif_serdes
   import ramif_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [SLOT_BITS-1:0]   slot_cnt,
   input  logic [ADDR_BITS-1:0]   load_addr,
   input  logic [RAMIF_WIDTH-1:0] data_bits,
   output logic [RAMIF_WIDTH-1:0] addr_bits,
   output logic [ADDR_BITS-1:0]   word
);

   localparam int DATA_SR_BITS = ADDR_BITS - RAMIF_WIDTH;

   logic [ADDR_BITS-1:0]    addr_sr;
   logic [DATA_SR_BITS-1:0] data_sr;
   logic                    slot_last;

   assign slot_last = (slot_cnt == SLOT_BITS'(SLOT_LEN - 1));

   // An idle slot loads zero, so addr_bits stays 0 for its whole address phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_sr <= '0;
      end else if (slot_last) begin
         addr_sr <= load_addr;
      end else begin
         addr_sr <= addr_sr >> RAMIF_WIDTH;
      end
   end

   // Shifting every cycle flushes stale nibbles; after three shifts the
   // register holds nibbles 0..2 and the last one arrives live on data_bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_sr <= '0;
      end else begin
         data_sr <= {data_bits, data_sr[DATA_SR_BITS-1:RAMIF_WIDTH]};
      end
   end

   assign addr_bits = addr_sr[RAMIF_WIDTH-1:0];
   assign word      = {data_bits, data_sr};

endmodule

// File: rtl/ramif_arbiter.sv
// Two-port slot arbiter for the nibble-serial RAM: render port wins by default,
// aux port is forced through after MAX_WAIT consecutive losses.
module ramif_arbiter
   import ramif_pkg::*;
#(
   parameter int MAX_WAIT = 3
) (
   input  logic            clk,
   input  logic            reset,
   ramif_arbiter_if.slave  bus
);

   localparam int WAIT_BITS = $clog2(MAX_WAIT + 1);

   logic [SLOT_BITS-1:0] slot_cnt;
   logic [WAIT_BITS-1:0] wait_cnt;
   owner_t               own_a;
   owner_t               own_d;
   owner_t               grant_entry;
   logic                 slot_last;
   logic                 win0;
   logic                 win1;
   logic [ADDR_BITS-1:0] load_addr;
   logic [ADDR_BITS-1:0] word;
   logic [1:0]           rvalid_q;
   logic [ADDR_BITS-1:0] rdata_q;

   assign slot_last = (slot_cnt == SLOT_BITS'(SLOT_LEN - 1));

   always_comb begin
      win0        = 1'b0;
      win1        = 1'b0;
      load_addr   = '0;
      grant_entry = OWNER_NONE;
      if (slot_last) begin
         if (bus.req[PORT_AUX] &&
             (!bus.req[PORT_RENDER] || wait_cnt == WAIT_BITS'(MAX_WAIT))) begin
            win1 = 1'b1;
         end else if (bus.req[PORT_RENDER]) begin
            win0 = 1'b1;
         end
      end
      if (win1) begin
         load_addr = bus.addr1;
      end else if (win0) begin
         load_addr = bus.addr0;
      end
      grant_entry.valid = win0 | win1;
      grant_entry.port  = win1;
   end

   // Owner pipeline advances once per slot: own_a covers the address phase,
   // own_d the data phase that completes at the end of the following slot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_cnt <= '0;
         wait_cnt <= '0;
         own_a    <= OWNER_NONE;
         own_d    <= OWNER_NONE;
         rvalid_q <= '0;
         rdata_q  <= '0;
      end else begin
         slot_cnt <= slot_last ? '0 : slot_cnt + 1'b1;
         rvalid_q <= '0;
         if (slot_last) begin
            own_a <= grant_entry;
            own_d <= own_a;
            if (own_d.valid) begin
               rdata_q  <= word;
               rvalid_q <= (own_d.port == PORT_AUX) ? 2'b10 : 2'b01;
            end
            if (bus.req[PORT_AUX] && !win1) begin
               if (wait_cnt != WAIT_BITS'(MAX_WAIT)) begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end else begin
               wait_cnt <= '0;
            end
         end
      end
   end

   ramif_serdes u_serdes (
      .clk       (clk),
      .rst       (reset),
      .slot_cnt  (slot_cnt),
      .load_addr (load_addr),
      .data_bits (bus.data_bits),
      .addr_bits (bus.addr_bits),
      .word      (word)
   );

   assign bus.gnt    = {win1, win0};
   assign bus.rvalid = rvalid_q;
   assign bus.rdata  = rdata_q;

endmodule
